// File: rtl/hex_keypad_entry_if.sv
// Keypad entry bundle: matrix scan lines, commit/discard pulses and the entry/value results.
// master = keypad/host side, slave = hex_keypad_entry.
interface hex_keypad_entry_if;
  logic [3:0]  row_n;
  logic        enter;
  logic        clear;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_strobe;
  logic [31:0] entry_word;
  logic [3:0]  digit_count;
  logic [31:0] value;
  logic        value_valid;

  modport master (
    output row_n, enter, clear,
    input  col_n, key_code, key_strobe, entry_word, digit_count, value, value_valid
  );

  modport slave (
    input  row_n, enter, clear,
    output col_n, key_code, key_strobe, entry_word, digit_count, value, value_valid
  );
endinterface

// File: rtl/hex_keypad_entry.sv
// 4x4 active-low keypad scanner with debounce, feeding a shift-in hex entry word
// that is committed to value on enter and discarded on clear.
module hex_keypad_entry #(
  parameter int unsigned SCAN_DIV         = 50000,
  parameter int unsigned DEBOUNCE_SAMPLES = 10
) (
  input  logic          clk,
  input  logic          rst,
  hex_keypad_entry_if.slave io_kp
);

  localparam int unsigned DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W      = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES + 1) : 1;
  localparam int unsigned ROWS       = 4;
  localparam int unsigned ENTRY_W    = 32;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned KEY_W      = 4;
  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_DONE = CNT_W'(DEBOUNCE_SAMPLES);
  localparam logic [DIGIT_W-1:0] CNT_SAT  = DIGIT_W'(MAX_DIGITS);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [3:0]         r_row_meta;
  logic [3:0]         r_row_sync;
  logic [DIV_W-1:0]   r_div;
  logic [1:0]         r_col;
  logic [1:0]         w_col_nx;
  logic [1:0]         r_row;
  logic [1:0]         w_row_nx;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [3:0]         r_col_n;
  logic [KEY_W-1:0]   r_key_code;
  logic [KEY_W-1:0]   w_key_nx;
  logic               r_key_strobe;
  logic               w_accept;
  logic               w_sample;
  logic               w_idle;
  logic               w_hit;
  logic [1:0]         w_hit_row;
  logic [2:0]         w_low_cnt;
  logic [ENTRY_W-1:0] r_entry_word;
  logic [DIGIT_W-1:0] r_digit_count;
  logic [ENTRY_W-1:0] r_value;
  logic               r_value_valid;
  logic               w_commit;
  logic               w_restart;

  function automatic logic [KEY_W-1:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [KEY_W-1:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Rows are asynchronous to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= io_kp.row_n;
      r_row_sync <= r_row_meta;
    end
  end

  // Sample period divider; the sample is taken on the last clk of each period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_sample) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_sample = (r_div == DIV_LAST);

  // Classify the synchronised rows: idle, single hit, or ghost (several low)
  always_comb begin
    w_low_cnt = 3'd0;
    w_hit_row = 2'd0;
    for (int i = 0; i < ROWS; i++) begin
      if (!r_row_sync[i]) begin
        w_low_cnt = w_low_cnt + 3'd1;
        w_hit_row = 2'(i);
      end
    end
    w_idle = (w_low_cnt == 3'd0);
    w_hit  = (w_low_cnt == 3'd1);
  end

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_SCAN;
      r_col        <= 2'd0;
      r_row        <= 2'd0;
      r_cnt        <= '0;
      r_col_n      <= 4'b1110;
      r_key_code   <= '0;
      r_key_strobe <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_col        <= w_col_nx;
      r_row        <= w_row_nx;
      r_cnt        <= w_cnt_nx;
      r_col_n      <= ~(4'b0001 << w_col_nx);
      r_key_strobe <= w_accept;
      if (w_accept) begin
        r_key_code <= w_key_nx;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_col_nx   = r_col;
    w_row_nx   = r_row;
    w_cnt_nx   = r_cnt;
    w_accept   = 1'b0;
    if (w_sample) begin
      case (r_state)
        ST_SCAN: begin
          if (w_hit) begin
            w_row_nx = w_hit_row;
            if (CNT_DONE <= CNT_W'(1)) begin
              w_accept   = 1'b1;
              w_cnt_nx   = '0;
              w_state_nx = ST_HELD;
            end else begin
              w_cnt_nx   = CNT_W'(1);
              w_state_nx = ST_DEBOUNCE;
            end
          end else begin
            w_col_nx = r_col + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (w_hit && (w_hit_row == r_row)) begin
            if (w_cnt_inc == CNT_DONE) begin
              w_accept   = 1'b1;
              w_cnt_nx   = '0;
              w_state_nx = ST_HELD;
            end else begin
              w_cnt_nx = w_cnt_inc;
            end
          end else begin
            w_cnt_nx   = '0;
            w_col_nx   = r_col + 2'd1;
            w_state_nx = ST_SCAN;
          end
        end
        ST_HELD: begin
          // Any non-idle sample restarts the release count; no auto-repeat
          if (w_idle) begin
            if (w_cnt_inc == CNT_DONE) begin
              w_cnt_nx   = '0;
              w_col_nx   = r_col + 2'd1;
              w_state_nx = ST_SCAN;
            end else begin
              w_cnt_nx = w_cnt_inc;
            end
          end else begin
            w_cnt_nx = '0;
          end
        end
        default: begin
          w_cnt_nx   = '0;
          w_state_nx = ST_SCAN;
        end
      endcase
    end
  end

  assign w_key_nx = key_map(w_row_nx, r_col);

  assign w_commit  = io_kp.enter && !io_kp.clear;
  assign w_restart = io_kp.enter || io_kp.clear;

  // Entry word: commit/discard empties it, and a coincident key becomes the sole digit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry_word  <= '0;
      r_digit_count <= '0;
      r_value       <= '0;
      r_value_valid <= 1'b0;
    end else begin
      r_value_valid <= w_commit;
      if (w_commit) begin
        r_value <= r_entry_word;
      end
      if (r_key_strobe) begin
        if (w_restart) begin
          r_entry_word  <= ENTRY_W'(r_key_code);
          r_digit_count <= DIGIT_W'(1);
        end else begin
          r_entry_word  <= {r_entry_word[ENTRY_W-KEY_W-1:0], r_key_code};
          r_digit_count <= (r_digit_count >= CNT_SAT) ? CNT_SAT : r_digit_count + DIGIT_W'(1);
        end
      end else if (w_restart) begin
        r_entry_word  <= '0;
        r_digit_count <= '0;
      end
    end
  end

  assign io_kp.col_n       = r_col_n;
  assign io_kp.key_code    = r_key_code;
  assign io_kp.key_strobe  = r_key_strobe;
  assign io_kp.entry_word  = r_entry_word;
  assign io_kp.digit_count = r_digit_count;
  assign io_kp.value       = r_value;
  assign io_kp.value_valid = r_value_valid;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Scoreboard bench for hex_keypad_entry: keypad matrix model, directed key/enter/clear
// sequences, monitor popping expected key and commit events.
module tb_hex_keypad_entry;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 3;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] entry;
    logic [3:0]  cnt;
  } key_exp_t;

  typedef struct packed {
    logic [31:0] value;
    logic [31:0] entry;
    logic [3:0]  cnt;
  } val_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] held;
  logic [3:0]  row_model;

  key_exp_t key_q[$];
  val_exp_t val_q[$];

  int checks = 0;
  int errors = 0;
  int n_keys = 0;
  int n_vals = 0;

  logic [31:0] m_entry;
  logic [3:0]  m_cnt;

  hex_keypad_entry_if kp();

  hex_keypad_entry #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_SAMPLES(DEB)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .io_kp(kp)
  );

  always #5 clk = ~clk;

  // Matrix model: a held key pulls its row low while its column is driven low
  always_comb begin
    row_model = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !kp.col_n[c]) row_model[r] = 1'b0;
  end
  assign kp.row_n = row_model;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] kmap(input int r, input int c);
    logic [63:0] tbl;
    int idx;
    tbl = 64'h123A_456B_789C_0FED;
    idx = r * 4 + c;
    return tbl[63-4*idx -: 4];
  endfunction

  task automatic expect_key(input logic [3:0] code);
    key_exp_t e;
    m_entry = {m_entry[27:0], code};
    m_cnt   = (m_cnt >= 4'd8) ? 4'd8 : m_cnt + 4'd1;
    e.code  = code;
    e.entry = m_entry;
    e.cnt   = m_cnt;
    key_q.push_back(e);
  endtask

  task automatic expect_val(input logic [31:0] v, input logic [31:0] ent, input logic [3:0] cnt);
    val_exp_t e;
    e.value = v;
    e.entry = ent;
    e.cnt   = cnt;
    val_q.push_back(e);
  endtask

  // Monitor: checks every key_strobe and value_valid against the queues
  logic     pend = 1'b0;
  logic     prev_vv = 1'b0;
  key_exp_t pend_e;
  val_exp_t ve;
  always @(negedge clk) begin
    if (rst) begin
      pend    = 1'b0;
      prev_vv = 1'b0;
    end else begin
      if (pend) begin
        chk("entry_after_key", kp.entry_word, pend_e.entry);
        chk("count_after_key", 32'(kp.digit_count), 32'(pend_e.cnt));
        pend = 1'b0;
      end
      if (prev_vv) chk("value_valid_width", 32'(kp.value_valid), 32'd0);
      if (kp.key_strobe) begin
        if (key_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key_strobe: got code %h expected none", kp.key_code);
        end else begin
          pend_e = key_q.pop_front();
          chk("key_code", 32'(kp.key_code), 32'(pend_e.code));
          pend = 1'b1;
        end
        n_keys++;
      end
      if (kp.value_valid && !prev_vv) begin
        if (val_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_value_valid: got value %h expected none", kp.value);
        end else begin
          ve = val_q.pop_front();
          chk("value", kp.value, ve.value);
          chk("entry_at_commit", kp.entry_word, ve.entry);
          chk("count_at_commit", 32'(kp.digit_count), 32'(ve.cnt));
        end
        n_vals++;
      end
      prev_vv = kp.value_valid;
    end
  end

  task automatic wait_keys(input int target);
    int n = 0;
    while (n_keys < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("key_strobe_seen", 32'(n_keys), 32'(target));
  endtask

  task automatic wait_vals(input int target);
    int n = 0;
    while (n_vals < target && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("value_valid_seen", 32'(n_vals), 32'(target));
  endtask

  task automatic wait_col(input logic [3:0] v);
    int n = 0;
    @(negedge clk);
    while (kp.col_n !== v && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("col_wait", 32'(kp.col_n), 32'(v));
  endtask

  task automatic press_key(input int r, input int c);
    int base = n_keys;
    expect_key(kmap(r, c));
    held[r*4+c] = 1'b1;
    wait_keys(base + 1);
    repeat (40) @(negedge clk);
    held[r*4+c] = 1'b0;
    repeat (50) @(negedge clk);
    chk("single_strobe", 32'(n_keys), 32'(base + 1));
  endtask

  task automatic pulse(input logic en, input logic cl);
    @(posedge clk);
    #1 kp.enter = en; kp.clear = cl;
    @(posedge clk);
    #1 kp.enter = 1'b0; kp.clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_state();
    chk("rst_col_n", 32'(kp.col_n), 32'(4'b1110));
    chk("rst_key_code", 32'(kp.key_code), 32'd0);
    chk("rst_key_strobe", 32'(kp.key_strobe), 32'd0);
    chk("rst_entry_word", kp.entry_word, 32'd0);
    chk("rst_digit_count", 32'(kp.digit_count), 32'd0);
    chk("rst_value", kp.value, 32'd0);
    chk("rst_value_valid", 32'(kp.value_valid), 32'd0);
  endtask

  initial begin
    logic [3:0] seq [4];
    int base;
    int n;
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;
    rst = 1'b1;
    held = '0;
    kp.enter = 1'b0;
    kp.clear = 1'b0;
    m_entry = '0;
    m_cnt = '0;
    repeat (3) @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle scan: each column held for exactly SCAN_DIV clocks
    n = 0;
    @(negedge clk);
    while (kp.col_n === 4'b1110 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 4; k++) begin
      chk("scan_col_first", 32'(kp.col_n), 32'(seq[(k+1)%4]));
      repeat (3) @(negedge clk);
      chk("scan_col_last", 32'(kp.col_n), 32'(seq[(k+1)%4]));
      @(negedge clk);
    end
    chk("idle_no_strobe", 32'(n_keys), 32'd0);

    // Single held key "6"
    press_key(1, 2);

    // Bounce: two hit samples then release -> nothing; then a clean press
    base = n_keys;
    wait_col(4'b1110);
    held[6] = 1'b1;
    wait_col(4'b1011);
    repeat (8) @(posedge clk);
    #1 held[6] = 1'b0;
    repeat (20) @(negedge clk);
    chk("bounce_no_strobe", 32'(n_keys), 32'(base));
    press_key(1, 2);
    chk("entry_66", kp.entry_word, 32'h66);

    // Nine digits, oldest falls off, then commit
    pulse(1'b0, 1'b1);
    chk("clear_entry", kp.entry_word, 32'd0);
    chk("clear_count", 32'(kp.digit_count), 32'd0);
    m_entry = '0;
    m_cnt = '0;
    for (int d = 1; d <= 9; d++) press_key((d - 1) / 3, (d - 1) % 3);
    chk("nine_entry", kp.entry_word, 32'h2345_6789);
    chk("nine_count", 32'(kp.digit_count), 32'd8);
    expect_val(32'h2345_6789, 32'd0, 4'd0);
    pulse(1'b1, 1'b0);
    wait_vals(1);
    m_entry = '0;
    m_cnt = '0;

    // Ghost: two keys in column 0 -> rejected until one is released
    base = n_keys;
    held[0] = 1'b1;
    held[4] = 1'b1;
    repeat (100) @(negedge clk);
    chk("ghost_no_strobe", 32'(n_keys), 32'(base));
    expect_key(4'h1);
    held[4] = 1'b0;
    wait_keys(base + 1);
    repeat (40) @(negedge clk);
    held[0] = 1'b0;
    repeat (50) @(negedge clk);

    // enter+clear together: clear wins, value kept
    pulse(1'b1, 1'b1);
    chk("ec_no_valid", 32'(kp.value_valid), 32'd0);
    chk("ec_entry", kp.entry_word, 32'd0);
    chk("ec_count", 32'(kp.digit_count), 32'd0);
    chk("ec_value_kept", kp.value, 32'h2345_6789);
    m_entry = '0;
    m_cnt = '0;
    press_key(0, 0);
    press_key(0, 1);
    chk("entry_12", kp.entry_word, 32'h12);

    // enter lands on the key_strobe cycle of "A"
    base = n_keys;
    wait_col(4'b1110);
    held[3] = 1'b1;
    wait_col(4'b0111);
    m_entry = '0;
    m_cnt = '0;
    expect_key(4'hA);
    expect_val(32'h12, 32'hA, 4'd1);
    repeat (12) @(posedge clk);
    #1 kp.enter = 1'b1;
    @(posedge clk);
    #1 kp.enter = 1'b0;
    wait_keys(base + 1);
    wait_vals(2);
    repeat (40) @(negedge clk);
    held[3] = 1'b0;
    repeat (50) @(negedge clk);

    // enter with no digits still commits 0
    pulse(1'b0, 1'b1);
    expect_val(32'd0, 32'd0, 4'd0);
    pulse(1'b1, 1'b0);
    wait_vals(3);
    m_entry = '0;
    m_cnt = '0;

    // Reset mid-debounce; the still-held "5" must be re-debounced
    base = n_keys;
    wait_col(4'b1110);
    held[5] = 1'b1;
    wait_col(4'b1101);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_state();
    expect_key(4'h5);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_keys(base + 1);
    repeat (40) @(negedge clk);
    held[5] = 1'b0;
    repeat (50) @(negedge clk);

    chk("key_queue_drained", 32'(key_q.size()), 32'd0);
    chk("val_queue_drained", 32'(val_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
